pipeline_v1r1: RTL and testbench

PIPELINE_V1R1 -- requirements
Module: pipeline_v1r1

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/pipeline_skid.sv | 89 ++++++++
 rtl/pipeline_v1r1.sv | 64 ++++++
 tb/tb_pipeline_v1r1.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared defaults and buffer-state encoding for the accumulating skid pipeline.
package pipeline_pkg;
  localparam int VALUE_BITS_DEF = 8;
  localparam int STATE_BITS_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;
endpackage

// File: rtl/pipeline_skid.sv
// Two-entry output buffer (main + skid) with fully registered valid/ready/data.
module pipeline_skid
  import pipeline_pkg::*;
#(
  parameter int VALUE_BITS = VALUE_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic [VALUE_BITS-1:0] i_value,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_valid,
  input  logic                  i_ready
);

  buf_state_e            state_q, state_d;
  logic [VALUE_BITS-1:0] main_q, main_d;
  logic [VALUE_BITS-1:0] skid_q, skid_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  accept;
  logic                  drain;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = i_valid & ready_q;
    drain   = valid_q & i_ready;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = i_value;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = i_value;
        end else if (accept) begin
          skid_d  = i_value;
          state_d = FULL;
        end else if (drain) begin
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so no accept can coincide with the drain
        if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = '0;
        state_d = EMPTY;
      end
    endcase
    if (i_clear) begin
      main_d  = '0;
      state_d = EMPTY;
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
    skid_q <= skid_d;
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_value = main_q;

endmodule

// File: rtl/pipeline_v1r1.sv
// Running-sum accumulator feeding a two-entry skid buffer; each accepted beat
// emits the low VALUE_BITS of the updated running sum.
module pipeline_v1r1
  import pipeline_pkg::*;
#(
  parameter int VALUE_BITS = VALUE_BITS_DEF,
  parameter int STATE_BITS = STATE_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic [VALUE_BITS-1:0] i_value,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [STATE_BITS-1:0] r_state_q, r_state_d;
  logic [STATE_BITS-1:0] sum;
  logic                  accept;

  function automatic logic [STATE_BITS-1:0] acc_add(
    input logic [STATE_BITS-1:0] acc,
    input logic [VALUE_BITS-1:0] val
  );
    return acc + STATE_BITS'(val);
  endfunction

  always_comb begin
    accept    = i_valid & o_ready;
    sum       = acc_add(r_state_q, i_value);
    r_state_d = r_state_q;
    if (i_clear) begin
      r_state_d = '0;
    end else if (accept) begin
      r_state_d = sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= '0;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  pipeline_skid #(
    .VALUE_BITS(VALUE_BITS)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_clear (i_clear),
    .i_value (sum[VALUE_BITS-1:0]),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

endmodule

// File: tb/tb_pipeline_v1r1.sv
// Bench for pipeline_v1r1: directed vector table, reset corner, random run vs prefix-sum model.
module tb_pipeline_v1r1;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_clear;
  logic [7:0] i_value;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_value;
  logic       o_valid;
  logic       i_ready;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pipeline_v1r1 #(.VALUE_BITS(8), .STATE_BITS(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_clear (i_clear),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  typedef struct {
    logic       v;
    logic [7:0] val;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] eval;
    logic       er;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] eval, input logic er);
    chk({tag, "_valid"}, int'(o_valid), int'(ev));
    chk({tag, "_value"}, int'(o_value), int'(eval));
    chk({tag, "_ready"}, int'(o_ready), int'(er));
  endtask

  initial begin
    logic [7:0] q[$];
    int         acc;
    int         accepted;
    int         cyc;
    logic       stalled_prev;
    logic [7:0] prev_value;
    logic       rv, rr, rc, exp_ready;
    logic [7:0] rval;

    //           v     val     rdy   clr   ev    eval    er
    vecs[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
    vecs[1]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
    vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[7]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[8]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h06, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 8'hEA, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
    vecs[11] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[14] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[15] = '{1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[16] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

    reset   = 1'b1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_value = 8'h00;
    i_ready = 1'b1;
    step();
    step();
    chk_out("reset", 1'b0, 8'h00, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      i_valid = vecs[i].v;
      i_value = vecs[i].val;
      i_ready = vecs[i].rdy;
      i_clear = vecs[i].clr;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eval, vecs[i].er);
    end
    i_clear = 1'b0;

    // Reset while FULL: nothing stale may appear afterwards.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_value = 8'h11;
    step();
    i_value = 8'h22;
    step();
    chk("full_before_reset_ready", int'(o_ready), 0);
    reset   = 1'b1;
    i_ready = 1'b1;
    i_value = 8'h33;
    step();
    chk_out("reset_full", 1'b0, 8'h00, 1'b1);
    reset   = 1'b0;
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_reset%0d_valid", i), int'(o_valid), 0);
    end
    i_valid = 1'b1;
    i_value = 8'h04;
    step();
    chk_out("post_reset_beat", 1'b1, 8'h04, 1'b1);
    i_valid = 1'b0;
    step();
    chk_out("post_reset_idle", 1'b0, 8'h00, 1'b1);

    // Random run against an ordered-queue prefix-sum model.
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    q.delete();
    acc          = 0;
    accepted     = 0;
    cyc          = 0;
    stalled_prev = 1'b0;
    prev_value   = 8'h00;
    while (accepted < 1000 && cyc < 20000) begin
      chk("rnd_valid", int'(o_valid), (q.size() != 0) ? 1 : 0);
      chk("rnd_value", int'(o_value), (q.size() != 0) ? int'(q[0]) : 0);
      chk("rnd_ready", int'(o_ready), (q.size() < 2) ? 1 : 0);
      if (stalled_prev) chk("rnd_stable", int'(o_value), int'(prev_value));
      rv   = ($urandom % 4) != 0;
      rval = 8'($urandom);
      rr   = ($urandom % 3) != 0;
      rc   = ($urandom % 97) == 0;
      i_valid = rv;
      i_value = rval;
      i_ready = rr;
      i_clear = rc;
      exp_ready    = q.size() < 2;
      stalled_prev = (q.size() != 0) && !rr && !rc;
      prev_value   = o_value;
      if (rc) begin
        q.delete();
        acc = 0;
      end else begin
        if (q.size() != 0 && rr) void'(q.pop_front());
        if (rv && exp_ready) begin
          acc = (acc + int'(rval)) % 256;
          q.push_back(8'(acc));
          accepted++;
        end
      end
      step();
      cyc++;
    end
    chk("rnd_budget", (accepted >= 1000) ? 1 : 0, 1);
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b1;
    while (q.size() != 0) begin
      chk("flush_value", int'(o_value), int'(q[0]));
      chk("flush_valid", int'(o_valid), 1);
      void'(q.pop_front());
      step();
    end
    chk_out("flush_end", 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
